// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: shared state encoding and constants for the data-memory responder
package data_mem_resp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} dm_state_t;
    localparam logic [3:0] DM_NO_WRITE = 4'b1111;
endpackage

// File: rtl/data_mem_resp_array.sv
// dm_array: word array with byte-masked synchronous write and combinational read
module dm_array #(
    parameter int DEPTH = 16384
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] index,
    input  logic [3:0]               be_n,
    input  logic [31:0]              din,
    output logic [31:0]              dout
);
    logic [31:0] r_mem [DEPTH];
    // update only the bytes whose active-low enable is asserted
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!be_n[i]) r_mem[index][8*i +: 8] <= din[8*i +: 8];
    end
    assign dout = r_mem[index];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: wait-state data memory with accept/busy/respond handshake
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH    = 16384,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_cs,
    input  logic [3:0]  dm_w_en,
    input  logic [13:0] dm_addr,
    input  logic [31:0] dm_din,
    output logic [31:0] dm_dout,
    output logic        dm_valid,
    output logic        dm_stall
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);
    dm_state_t   r_state, w_next;
    logic [3:0]  r_cnt, r_wen, w_wen, w_be_n;
    logic [13:0] r_addr, w_addr;
    logic [31:0] r_din, r_dout, w_din, w_rdata;
    logic        w_accept, w_fire, w_read;
    assign w_accept = dm_cs & ~rst & (r_state == IDLE || r_state == RESP);
    // the array is touched on the edge that enters RESP; with no wait cycles that is the accept edge itself
    assign w_fire   = ~rst & ((r_state == BUSY && r_cnt == 4'd1) || (w_accept && WAIT_CYC == 0));
    assign w_addr   = r_state == BUSY ? r_addr : dm_addr;
    assign w_wen    = r_state == BUSY ? r_wen  : dm_w_en;
    assign w_din    = r_state == BUSY ? r_din  : dm_din;
    assign w_be_n   = w_fire ? w_wen : DM_NO_WRITE;
    assign w_read   = w_fire && w_wen == DM_NO_WRITE;
    assign dm_dout  = r_dout;
    dm_array #(.DEPTH(DEPTH)) u_array (
        .clk  (clk),
        .index(w_addr[AW-1:0]),
        .be_n (w_be_n),
        .din  (w_din),
        .dout (w_rdata)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: accept wins, BUSY counts down to RESP, anything else idles
    always_comb begin
        w_next = w_accept ? (WAIT_CYC == 0 ? RESP : BUSY)
               : r_state == BUSY ? (r_cnt == 4'd1 ? RESP : BUSY)
               : IDLE;
    end
    // handshake outputs
    always_comb begin
        dm_valid = r_state == RESP;
        dm_stall = w_accept | (r_state == BUSY);
    end
    // request latches, wait counter and read-data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_addr <= 14'd0;
            r_wen  <= DM_NO_WRITE;
            r_din  <= 32'd0;
            r_dout <= 32'd0;
        end else begin
            r_cnt  <= w_accept ? WAIT_INIT : r_state == BUSY ? r_cnt - 4'd1 : r_cnt;
            r_addr <= w_accept ? dm_addr : r_addr;
            r_wen  <= w_accept ? dm_w_en : r_wen;
            r_din  <= w_accept ? dm_din : r_din;
            r_dout <= w_read ? w_rdata : r_dout;
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: randomized self-checking bench with a word/byte memory model
module tb_data_mem_resp;
    localparam int DEPTH = 16384;
    localparam int W     = 2;
    logic        clk = 0, rst = 1;
    logic        cs = 0, cs0 = 0;
    logic [3:0]  w_en = 4'hF, wen0 = 4'hF;
    logic [13:0] a = 0, a0 = 0;
    logic [31:0] d = 0, d0 = 0;
    logic [31:0] dout, dout0;
    logic        valid, stall, valid0, stall0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] model [int];
    logic [31:0] last_rd = 32'h0;

    data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst), .dm_cs(cs), .dm_w_en(w_en), .dm_addr(a), .dm_din(d),
        .dm_dout(dout), .dm_valid(valid), .dm_stall(stall)
    );
    data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .dm_cs(cs0), .dm_w_en(wen0), .dm_addr(a0), .dm_din(d0),
        .dm_dout(dout0), .dm_valid(valid0), .dm_stall(stall0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd, input logic [3:0] be_n);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (!be_n[i]) r[8*i +: 8] = nd[8*i +: 8];
        return r;
    endfunction

    task automatic access(input logic [3:0] wen, input logic [13:0] addr, input logic [31:0] din, input bit b2b);
        int lat, st, idx;
        idx = int'(addr) % DEPTH;
        cs = 1; w_en = wen; a = addr; d = din;
        #1;
        st = int'(stall);
        @(posedge clk); #1;
        cs = 0; w_en = 4'($urandom); a = 14'($urandom); d = $urandom;
        lat = 1;
        while (!valid && lat < 20) begin
            st += int'(stall);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, W + 1);
        chk("stall_cycles", st, 3);
        chk("stall_in_resp", {31'd0, stall}, 0);
        if (wen != 4'hF) model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, din, wen);
        else last_rd = model[idx];
        chk(wen == 4'hF ? "read_data" : "dout_hold_on_write", dout, last_rd);
        if (!b2b) begin
            @(posedge clk); #1;
            chk("valid_drop", {31'd0, valid}, 0);
        end
    endtask

    initial begin
        cs = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        rst = 0; cs = 0;
        access(4'h0, 14'd5, 32'hDEADBEEF, 0);
        access(4'hF, 14'd5, 32'h0, 0);
        chk("rw_addr5", dout, 32'hDEADBEEF);
        access(4'h0, 14'd7, 32'h11223344, 0);
        access(4'hE, 14'd7, 32'h000000AA, 0);
        access(4'hC, 14'd7, 32'h0000BBCC, 0);
        access(4'hF, 14'd7, 32'h0, 0);
        chk("sb_sh_merge", dout, 32'h1122BBCC);
        access(4'h0, 14'(16384 + 3), 32'hCAFEF00D, 0);
        access(4'hF, 14'd3, 32'h0, 0);
        chk("wrap", dout, 32'hCAFEF00D);
        access(4'h0, 14'd11, $urandom, 1);
        access(4'hF, 14'd11, 32'h0, 0);
        access(4'h0, 14'd2, 32'h0, 0);
        cs = 1; w_en = 4'h0; a = 14'd2; d = 32'hFFFFFFFF;
        @(posedge clk); #1;
        cs = 0;
        @(posedge clk); #1;
        chk("busy_stall", {31'd0, stall}, 1);
        rst = 1;
        #1;
        chk("async_rst_dout", dout, 0);
        chk("async_rst_valid", {31'd0, valid}, 0);
        chk("async_rst_stall", {31'd0, stall}, 0);
        last_rd = 32'h0;
        @(posedge clk); #1;
        rst = 0;
        access(4'hF, 14'd2, 32'h0, 0);
        chk("rst_discard", dout, 32'h0);
        d0 = $urandom;
        cs0 = 1; wen0 = 4'h0; a0 = 14'd9;
        #1;
        chk("w0_stall_accept", {31'd0, stall0}, 1);
        @(posedge clk); #1;
        chk("w0_valid_wr", {31'd0, valid0}, 1);
        wen0 = 4'hF;
        #1;
        chk("w0_stall_b2b", {31'd0, stall0}, 1);
        @(posedge clk); #1;
        chk("w0_valid_rd", {31'd0, valid0}, 1);
        chk("w0_rd_data", dout0, d0);
        cs0 = 0;
        @(posedge clk); #1;
        chk("w0_valid_drop", {31'd0, valid0}, 0);
        for (int i = 12; i < 44; i++) access(4'h0, 14'(i), $urandom, 1'($urandom));
        for (int i = 0; i < 40; i++)
            access(4'($urandom_range(0, 15)), 14'($urandom_range(12, 43)), $urandom, 1'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 16384, number of 32-bit words in the array; SHALL be a power of two.
REQ-002 Parameter WAIT_CYC, default 1, extra wait cycles per access; legal range 0..15.
REQ-003 Port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-high.
REQ-005 Port dm_cs, input, 1, request present when 1.
REQ-006 Port dm_w_en, input, 4, active-low byte write enables; bit i=0 writes byte i; 4'b1111 means read.
REQ-007 Port dm_addr, input, 14, word address.
REQ-008 Port dm_din, input, 32, store data; byte i is bits 8i+7..8i.
REQ-009 Port dm_dout, output, 32, registered read data.
REQ-010 Port dm_valid, output, 1, one-cycle pulse marking completion of an access.
REQ-011 Port dm_stall, output, 1, requester SHALL hold all inputs while this is 1.

Function
REQ-012 The state machine SHALL have three states: IDLE, BUSY and RESP.
REQ-013 Accept occurs when dm_cs=1 and state is IDLE or RESP; on accept the block SHALL latch dm_addr, dm_w_en and dm_din and load the wait counter with WAIT_CYC.
REQ-014 On accept: WAIT_CYC=0 -> next state RESP; otherwise -> BUSY.
REQ-015 In BUSY the counter SHALL decrement each cycle; at count 1 -> RESP.
REQ-016 The array access SHALL be performed on the clock edge that enters RESP.
REQ-017 Completion latency: dm_valid=1 exactly WAIT_CYC+1 cycles after the accept cycle.
REQ-018 Write (latched w_en != 4'b1111): only bytes with w_en bit 0 are updated; the other bytes keep their contents; dm_dout is unchanged.
REQ-019 Read (latched w_en = 4'b1111): dm_dout SHALL load the full word and hold it until the next read completes.
REQ-020 dm_valid SHALL be 1 only in RESP, for both reads and writes.
REQ-021 dm_stall = (accept in the current cycle) OR (state = BUSY); dm_stall SHALL be 0 in the RESP cycle unless a new accept occurs in that cycle.
REQ-022 RESP with dm_cs=1 SHALL accept back-to-back with no idle cycle; RESP with dm_cs=0 -> IDLE.
REQ-023 dm_cs=0 in IDLE: no state change, no array access.
REQ-024 The array index SHALL be dm_addr modulo DEPTH (low bits; addresses wrap around).
REQ-025 A read accepted in the RESP cycle of a write to the same address SHALL return the newly written bytes.
REQ-026 Input changes during BUSY SHALL be ignored; only the latched values are used.

Reset
REQ-027 On rst=1, immediately and independent of clk: state=IDLE, counter=0, dm_dout=32'h0, dm_valid=0, dm_stall=0.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 A reset during BUSY SHALL discard the pending access; no array byte is modified.
REQ-030 The first accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 The state enum and the constant DM_NO_WRITE = 4'b1111 SHALL live in the shared define package, shared with the M-stage controller.
REQ-032 Storage SHALL be a sub-module dm_array: synchronous, byte-masked, with ports clk, index, active-low byte enables, din and dout.
REQ-033 The FSM, counter and output registers SHALL reside in data_mem_resp.

Verification (DEPTH=16384, WAIT_CYC=2 unless stated)
REQ-034 Write addr 5, w_en 0000, din 32'hDEADBEEF; then read addr 5 -> dm_dout=32'hDEADBEEF; dm_valid 3 cycles after each accept; dm_stall=1 for 3 cycles per access.
REQ-035 Addr 7 preloaded 32'h11223344; write w_en 1110, din 32'h000000AA (sb); then w_en 1100, din 32'h0000BBCC (sh); read -> 32'h1122BBCC.
REQ-036 WAIT_CYC=0: write then read addr 9 with dm_cs held 1 -> dm_valid high on consecutive cycles; the read returns the written word.
REQ-037 Write addr 16384+3 with 32'hCAFEF00D; read addr 3 -> 32'hCAFEF00D (wrap-around).
REQ-038 Addr 2 holds 32'h0; assert rst in the 2nd BUSY cycle of a write to addr 2 -> outputs zero immediately, state IDLE; a later read of addr 2 -> 32'h0.
